reg_file_2w: RTL and testbench

REG_FILE_2W -- requirements
Module: reg_file_2w

---
 rtl/reg_file_2w.sv | 174 +++++++++++++++++
 tb/tb_reg_file_2w.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2w.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_2w
//  Description : Register file with two write ports, three combinational read
//                ports, optional same-cycle write forwarding, optional
//                hardwired-zero register 0, Zero/Carry/Done flag registers
//                and a HALT/RUN controller that gates every write.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_2w #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic         Running,
    input  logic         WeA,
    input  logic [D-1:0] WaddrA,
    input  logic [W-1:0] WdataA,
    input  logic         WeB,
    input  logic [D-1:0] WaddrB,
    input  logic [W-1:0] WdataB,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    input  logic [D-1:0] RaddrC,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic [W-1:0] DataOutC,
    input  logic         FlagWe,
    input  logic         ZeroIn,
    input  logic         CarryIn,
    input  logic         DoneIn,
    output logic         ZeroOut,
    output logic         CarryOut,
    output logic         DoneOut
);

    localparam int NREG = 2 ** D;

    localparam logic [0:0] c_HALT = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_next_state;
    logic         w_run;
    logic         w_acc_a;
    logic         w_acc_b;
    logic         w_flag_wr;
    logic [W-1:0] r_regs [NREG];
    logic         r_zero;
    logic         r_carry;
    logic         r_done;

    assign w_run = (r_state == c_RUN);

    // A write is accepted only in RUN; address 0 is read-only when hardwired.
    assign w_acc_a   = w_run && WeA && !((R0_ZERO != 0) && (WaddrA == '0));
    assign w_acc_b   = w_run && WeB && !((R0_ZERO != 0) && (WaddrB == '0));
    assign w_flag_wr = w_run && FlagWe;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_HALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: Start launches from HALT, a flag write carrying Done halts.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_HALT: begin
                if (Start) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (FlagWe && DoneIn) begin
                    w_next_state = c_HALT;
                end
            end
            default: w_next_state = c_HALT;
        endcase
    end

    // Controller outputs.
    always_comb begin
        Running = 1'b0;
        if (r_state == c_RUN) begin
            Running = 1'b1;
        end
    end

    // Register array; port B is written last so it wins an address collision.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_acc_a) begin
                r_regs[WaddrA] <= WdataA;
            end
            if (w_acc_b) begin
                r_regs[WaddrB] <= WdataB;
            end
        end
    end

    // Flag registers: Zero/Carry follow flag writes, Done is cleared on launch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_done  <= 1'b1;
        end else begin
            if (!w_run && Start) begin
                r_done <= 1'b0;
            end
            if (w_flag_wr) begin
                r_zero  <= ZeroIn;
                r_carry <= CarryIn;
                if (DoneIn) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign ZeroOut  = r_zero;
    assign CarryOut = r_carry;
    assign DoneOut  = r_done;

    // One read port: hardwired zero first, then forwarded data (B over A),
    // then the stored value.
    function automatic logic [W-1:0] f_read(
        input logic [D-1:0] addr,
        input logic [W-1:0] stored,
        input logic         acc_a,
        input logic [D-1:0] waddr_a,
        input logic [W-1:0] wdata_a,
        input logic         acc_b,
        input logic [D-1:0] waddr_b,
        input logic [W-1:0] wdata_b
    );
        logic [W-1:0] v;
        v = stored;
        if ((R0_ZERO != 0) && (addr == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && acc_b && (waddr_b == addr)) begin
            v = wdata_b;
        end else if ((BYPASS != 0) && acc_a && (waddr_a == addr)) begin
            v = wdata_a;
        end
        return v;
    endfunction

    // Combinational read ports.
    always_comb begin
        DataOutA = f_read(RaddrA, r_regs[RaddrA], w_acc_a, WaddrA, WdataA,
                          w_acc_b, WaddrB, WdataB);
        DataOutB = f_read(RaddrB, r_regs[RaddrB], w_acc_a, WaddrA, WdataA,
                          w_acc_b, WaddrB, WdataB);
        DataOutC = f_read(RaddrC, r_regs[RaddrC], w_acc_a, WaddrA, WdataA,
                          w_acc_b, WaddrB, WdataB);
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_2w
//  Description : Self-checking bench for reg_file_2w. Two instances share one
//                stimulus stream: inst 0 (BYPASS=1, R0_ZERO=0) and inst 1
//                (BYPASS=0, R0_ZERO=1). A behavioural model predicts outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_2w;

    logic       Clk = 1'b0;
    logic       Reset, Start, WeA, WeB, FlagWe, ZeroIn, CarryIn, DoneIn;
    logic [3:0] WaddrA, WaddrB, RaddrA, RaddrB, RaddrC;
    logic [7:0] WdataA, WdataB;

    logic [7:0] a0, b0, c0, a1, b1, c1;
    logic       z0, cy0, dn0, run0, z1, cy1, dn1, run1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    reg_file_2w #(.W(8), .D(4), .BYPASS(1), .R0_ZERO(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Running(run0),
        .WeA(WeA), .WaddrA(WaddrA), .WdataA(WdataA),
        .WeB(WeB), .WaddrB(WaddrB), .WdataB(WdataB),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .RaddrC(RaddrC),
        .DataOutA(a0), .DataOutB(b0), .DataOutC(c0),
        .FlagWe(FlagWe), .ZeroIn(ZeroIn), .CarryIn(CarryIn), .DoneIn(DoneIn),
        .ZeroOut(z0), .CarryOut(cy0), .DoneOut(dn0)
    );

    reg_file_2w #(.W(8), .D(4), .BYPASS(0), .R0_ZERO(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Running(run1),
        .WeA(WeA), .WaddrA(WaddrA), .WdataA(WdataA),
        .WeB(WeB), .WaddrB(WaddrB), .WdataB(WdataB),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .RaddrC(RaddrC),
        .DataOutA(a1), .DataOutB(b1), .DataOutC(c1),
        .FlagWe(FlagWe), .ZeroIn(ZeroIn), .CarryIn(CarryIn), .DoneIn(DoneIn),
        .ZeroOut(z1), .CarryOut(cy1), .DoneOut(dn1)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m0 [16];
    logic [7:0] m1 [16];
    bit m_run = 0, m_zero = 0, m_carry = 0, m_done = 1;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                m0[i] = 8'h00;
                m1[i] = 8'h00;
            end
            m_run = 0; m_zero = 0; m_carry = 0; m_done = 1;
        end else if (!m_run) begin
            if (Start) begin
                m_run  = 1;
                m_done = 0;
            end
        end else begin
            if (WeA) m0[WaddrA] = WdataA;
            if (WeB) m0[WaddrB] = WdataB;
            if (WeA && WaddrA != 0) m1[WaddrA] = WdataA;
            if (WeB && WaddrB != 0) m1[WaddrB] = WdataB;
            if (FlagWe) begin
                m_zero  = ZeroIn;
                m_carry = CarryIn;
                if (DoneIn) begin
                    m_done = 1;
                    m_run  = 0;
                end
            end
        end
    end

    // Expected read value of one port of one instance, given current inputs.
    function automatic logic [7:0] exp_rd(input int inst, input logic [3:0] addr);
        if (inst == 1) begin
            if (addr == 0) return 8'h00;
            return m1[addr];
        end
        if (m_run && WeB && WaddrB == addr) return WdataB;
        if (m_run && WeA && WaddrA == addr) return WdataA;
        return m0[addr];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("m0_rdA", a0, exp_rd(0, RaddrA));
            check("m0_rdB", b0, exp_rd(0, RaddrB));
            check("m0_rdC", c0, exp_rd(0, RaddrC));
            check("m1_rdA", a1, exp_rd(1, RaddrA));
            check("m1_rdB", b1, exp_rd(1, RaddrB));
            check("m1_rdC", c1, exp_rd(1, RaddrC));
            check("m0_flags", {z0, cy0, dn0, run0}, {m_zero, m_carry, m_done, m_run});
            check("m1_flags", {z1, cy1, dn1, run1}, {m_zero, m_carry, m_done, m_run});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Start = 0; WeA = 0; WeB = 0; FlagWe = 0;
    endtask

    initial begin
        Reset = 1; idle();
        ZeroIn = 0; CarryIn = 0; DoneIn = 0;
        WaddrA = 0; WaddrB = 0; WdataA = 0; WdataB = 0;
        RaddrA = 0; RaddrB = 0; RaddrC = 0;
        tick();
        chk_en = 1;
        check("rst_done", dn0, 1);
        check("rst_run", run0, 0);
        check("rst_zc", {z0, cy0}, 2'b00);
        check("rst_rdA", a0, 8'h00);

        // Writes in HALT are ignored.
        Reset = 0;
        WeA = 1; WaddrA = 3; WdataA = 8'h5A; RaddrA = 3;
        tick(); idle(); #1;
        check("halt_wr_reg3", a0, 8'h00);
        check("halt_wr_reg3_i1", a1, 8'h00);
        check("halt_done", dn0, 1);
        check("halt_run", run0, 0);

        // Start edge ignores a simultaneous write.
        Start = 1; WeA = 1; WaddrA = 4; WdataA = 8'h77; RaddrB = 4;
        tick(); idle(); #1;
        check("start_run", run0, 1);
        check("start_done", dn0, 0);
        check("start_wr_reg4", b0, 8'h00);

        // Both ports to reg2: B wins, forwarded only on inst 0.
        WeA = 1; WaddrA = 2; WdataA = 8'h11;
        WeB = 1; WaddrB = 2; WdataB = 8'h22; RaddrA = 2; #1;
        check("byp_prioB", a0, 8'h22);
        check("nobyp_old2", a1, 8'h00);
        tick(); idle(); #1;
        check("reg2_i0", a0, 8'h22);
        check("reg2_i1", a1, 8'h22);

        // Forwarding on read port C.
        WeB = 1; WaddrB = 5; WdataB = 8'hC3; RaddrC = 5; #1;
        check("byp_C", c0, 8'hC3);
        check("nobyp_C", c1, 8'h00);
        tick(); idle(); #1;
        check("reg5_i0", c0, 8'hC3);
        check("reg5_i1", c1, 8'hC3);

        // Register 0: hardwired on inst 1, ordinary on inst 0.
        WeA = 1; WaddrA = 0; WdataA = 8'hFF; RaddrA = 0; #1;
        check("r0_pre_i1", a1, 8'h00);
        check("r0_pre_i0", a0, 8'hFF);
        tick(); idle(); #1;
        check("r0_post_i1", a1, 8'h00);
        check("r0_post_i0", a0, 8'hFF);

        // Pattern sweep with both ports active.
        for (int i = 0; i < 8; i++) begin
            WeA = 1; WaddrA = 4'(i); WdataA = 8'(i * 3 + 1);
            WeB = 1; WaddrB = 4'(15 - i); WdataB = 8'hF0 ^ 8'(i);
            RaddrA = 4'(i); RaddrB = 4'(15 - i); RaddrC = 4'(i + 1);
            tick();
        end
        idle();

        // Start while running is ignored.
        Start = 1;
        tick(); idle(); #1;
        check("start_in_run", run0, 1);
        check("start_in_run_done", dn0, 0);

        // Flag write without Done keeps running.
        FlagWe = 1; ZeroIn = 0; CarryIn = 1; DoneIn = 0;
        tick(); idle(); #1;
        check("flag1_zc", {z0, cy0}, 2'b01);
        check("flag1_run", run0, 1);

        // Flag write with Done halts.
        FlagWe = 1; ZeroIn = 1; CarryIn = 1; DoneIn = 1;
        tick(); idle(); #1;
        check("flag2_zcd", {z0, cy0, dn0}, 3'b111);
        check("flag2_run", run0, 0);

        // Flag and register writes in HALT are ignored.
        FlagWe = 1; ZeroIn = 0; CarryIn = 0; DoneIn = 0;
        WeA = 1; WaddrA = 6; WdataA = 8'hAA; RaddrA = 6;
        tick(); idle(); #1;
        check("halt_flag_zcd", {z0, cy0, dn0}, 3'b111);
        check("halt_flag_run", run0, 0);
        check("halt_reg6", a0, 8'h13);

        // Relaunch, write, then Reset mid-RUN with everything active.
        Start = 1;
        tick(); idle();
        WeA = 1; WaddrA = 7; WdataA = 8'h5E; WeB = 1; WaddrB = 9; WdataB = 8'h9B;
        tick(); idle();
        Reset = 1; Start = 1; FlagWe = 1; ZeroIn = 1; CarryIn = 1; DoneIn = 0;
        WeA = 1; WaddrA = 1; WdataA = 8'h44; WeB = 1; WaddrB = 2; WdataB = 8'h55;
        tick(); Reset = 0; idle(); #1;
        check("rst2_run", run0, 0);
        check("rst2_done", dn0, 1);
        check("rst2_zc", {z0, cy0}, 2'b00);
        for (int i = 0; i < 16; i++) begin
            RaddrA = 4'(i); #1;
            check("rst2_reg_i0", a0, 8'h00);
            check("rst2_reg_i1", a1, 8'h00);
        end

        // Reset beats Start on the same edge.
        Reset = 1; Start = 1;
        tick(); Reset = 0; idle(); #1;
        check("rst_vs_start", run0, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
